// File: rtl/axis_rr_pkg.sv
// Shared definitions for the round-robin AXIS merger: the channel-tag width
// helper and the output-register state encoding.
package axis_rr_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Rotating priority search: picks the first requester after the last granted
// channel, wrapping modulo N_CH.
module axis_rr_pick
  import axis_rr_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int ID_WIDTH = clog2(N_CH)
) (
  input  logic [N_CH-1:0]     req,
  input  logic [ID_WIDTH-1:0] last,
  output logic [ID_WIDTH-1:0] sel,
  output logic                any
);

  always_comb begin : search
    logic found;
    int   idx;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    // Starting at last+1 means the channel just served is checked last.
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(last) + k) % N_CH;
      if (!found && req[idx[ID_WIDTH-1:0]]) begin
        sel   = ID_WIDTH'(idx);
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/axis_rr_mux.sv
// Round-robin merge of N_CH AXI-Stream inputs into one registered output,
// tagging each beat with its source channel in tuser.
module axis_rr_mux
  import axis_rr_pkg::*;
#(
  parameter  int N_CH       = 4,
  parameter  int DATA_WIDTH = 24,
  localparam int ID_WIDTH   = clog2(N_CH)
) (
  input  logic                       aclk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            en_mask,
  input  logic [N_CH*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N_CH-1:0]            s_axis_tvalid,
  output logic [N_CH-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [ID_WIDTH-1:0]        m_axis_tuser,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready
);

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [ID_WIDTH-1:0]   user_reg;
  logic [ID_WIDTH-1:0]   last_reg;

  logic [N_CH-1:0]       req;
  logic [DATA_WIDTH-1:0] chan_data [N_CH];
  logic [DATA_WIDTH-1:0] data_next;
  logic [ID_WIDTH-1:0]   sel;
  logic                  any;
  logic                  load;

  axis_rr_pick #(
    .N_CH     (N_CH),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req  (req),
    .last (last_reg),
    .sel  (sel),
    .any  (any)
  );

  // The output register can take a new beat when empty or being drained now.
  assign load = (state_reg == EMPTY) | m_axis_tready;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    assign req[gi]           = s_axis_tvalid[gi] & en_mask[gi];
    assign chan_data[gi]     = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign s_axis_tready[gi] = ~rst & load & any & (sel == ID_WIDTH'(gi));
  end

  assign data_next = chan_data[sel];

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_reg <= EMPTY;
      data_reg  <= '0;
      user_reg  <= '0;
      last_reg  <= ID_WIDTH'(N_CH - 1);
    end else if (load) begin
      if (any) begin
        state_reg <= FULL;
        data_reg  <= data_next;
        user_reg  <= sel;
        last_reg  <= sel;
      end else begin
        // Nothing to send: the beat just drained leaves the register empty.
        state_reg <= EMPTY;
      end
    end
  end

  assign m_axis_tvalid = (state_reg == FULL);
  assign m_axis_tdata  = data_reg;
  assign m_axis_tuser  = user_reg;

endmodule

// File: tb/tb_axis_rr_mux.sv
// Self-checking bench for axis_rr_mux: vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_axis_rr_mux;

  localparam int N_CH = 4;
  localparam int DW   = 24;
  localparam int IW   = 2;

  logic               aclk = 1'b0;
  logic               rst;
  logic [N_CH-1:0]    en_mask;
  logic [N_CH*DW-1:0] s_tdata;
  logic [N_CH-1:0]    s_tvalid;
  logic [N_CH-1:0]    s_tready;
  logic [DW-1:0]      m_tdata;
  logic [IW-1:0]      m_tuser;
  logic               m_tvalid;
  logic               m_tready;

  int n_tests = 0;
  int n_fail  = 0;

  axis_rr_mux #(.N_CH(N_CH), .DATA_WIDTH(DW)) dut (
    .aclk          (aclk),
    .rst           (rst),
    .en_mask       (en_mask),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  mask;
    logic        mtready;
    logic [3:0]  exp_rdy;
    logic        exp_v;
    logic [1:0]  exp_u;
    logic [23:0] exp_d;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_chan(input int ch, input logic [DW-1:0] d);
    s_tdata[ch*DW +: DW] = d;
  endtask

  task automatic check_out(input string name, input logic v, input logic [1:0] u, input logic [23:0] d);
    check({name, ".tvalid"}, 32'(m_tvalid), 32'(v));
    check({name, ".tuser"},  32'(m_tuser),  32'(u));
    check({name, ".tdata"},  32'(m_tdata),  32'(d));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Reference model state for the random phase.
  logic          mdl_valid;
  logic [1:0]    mdl_user;
  logic [DW-1:0] mdl_data;
  int            mdl_last;
  logic [25:0]   sb_q [$];

  initial begin
    tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 24'd1};
    tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 24'd2};
    tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 24'd3};
    tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 24'd4};
    tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 24'd1};
    tbl[5]  = '{4'hF, 4'hA, 1'b1, 4'b0010, 1'b1, 2'd1, 24'd2};
    tbl[6]  = '{4'hF, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd3, 24'd4};
    tbl[7]  = '{4'hF, 4'hA, 1'b1, 4'b0010, 1'b1, 2'd1, 24'd2};
    tbl[8]  = '{4'hF, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd3, 24'd4};
    tbl[9]  = '{4'hF, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd3, 24'd4};
    tbl[10] = '{4'hF, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd3, 24'd4};
    tbl[11] = '{4'h0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd3, 24'd4};
    tbl[12] = '{4'h0, 4'hF, 1'b0, 4'b0000, 1'b0, 2'd3, 24'd4};

    rst      = 1'b1;
    en_mask  = 4'hF;
    s_tvalid = 4'h0;
    s_tdata  = '0;
    m_tready = 1'b0;
    tick();
    tick();
    s_tvalid = 4'hF;
    #1;
    check("reset.tready", 32'(s_tready), 32'h0);
    check_out("reset", 1'b0, 2'd0, 24'd0);
    rst = 1'b0;
    s_tvalid = 4'h0;

    // Vector table: rotation, mask 1010, stall, drain.
    for (int i = 0; i < N_CH; i++) set_chan(i, DW'(i + 1));
    for (int r = 0; r < 13; r++) begin
      s_tvalid = tbl[r].valid;
      en_mask  = tbl[r].mask;
      m_tready = tbl[r].mtready;
      #1;
      check($sformatf("vec%0d.tready", r), 32'(s_tready), 32'(tbl[r].exp_rdy));
      tick();
      check_out($sformatf("vec%0d", r), tbl[r].exp_v, tbl[r].exp_u, tbl[r].exp_d);
      $display("[TB] vec %0d: tready=%b out v=%0b u=%0d d=%06h", r, s_tready, m_tvalid, m_tuser, m_tdata);
    end

    // Lone requester on channel 2 gets every cycle.
    en_mask  = 4'hF;
    m_tready = 1'b1;
    set_chan(2, 24'h0000FF);
    s_tvalid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("lone.tready", 32'(s_tready), 32'b0100);
      tick();
      check_out("lone", 1'b1, 2'd2, 24'h0000FF);
      $display("[TB] lone beat %0d: u=%0d d=%06h", c, m_tuser, m_tdata);
    end

    // Stall: output held for 5 cycles, accepted when tready rises.
    set_chan(1, 24'h8000FF);
    s_tvalid = 4'b0010;
    #1;
    check("stall.load_tready", 32'(s_tready), 32'b0010);
    tick();
    check_out("stall.load", 1'b1, 2'd1, 24'h8000FF);
    m_tready = 1'b0;
    set_chan(1, 24'h123456);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall.tready", 32'(s_tready), 32'h0);
      tick();
      check_out("stall.hold", 1'b1, 2'd1, 24'h8000FF);
      $display("[TB] stall cycle %0d: d=%06h", c, m_tdata);
    end
    m_tready = 1'b1;
    #1;
    check("stall.release_tready", 32'(s_tready), 32'b0010);
    tick();
    check_out("stall.release", 1'b1, 2'd1, 24'h123456);
    s_tvalid = 4'h0;
    tick();
    check("stall.drain", 32'(m_tvalid), 32'h0);

    // Reset while FULL and stalled after serving channel 2.
    set_chan(2, 24'h0000AA);
    s_tvalid = 4'b0100;
    tick();
    m_tready = 1'b0;
    tick();
    check_out("rst.pre", 1'b1, 2'd2, 24'h0000AA);
    rst = 1'b1;
    s_tvalid = 4'b1101;
    #1;
    check("rst.tready_during", 32'(s_tready), 32'h0);
    tick();
    check_out("rst.after", 1'b0, 2'd0, 24'd0);
    rst = 1'b0;
    s_tvalid = 4'h0;
    m_tready = 1'b1;
    tick();
    check("rst.no_beat", 32'(m_tvalid), 32'h0);
    s_tvalid = 4'b1101;
    #1;
    check("rst.first_grant", 32'(s_tready), 32'b0001);
    tick();
    check_out("rst.first_beat", 1'b1, 2'd0, 24'd1);
    $display("[TB] post-reset beat: u=%0d d=%06h", m_tuser, m_tdata);

    // Random traffic against the reference model.
    s_tvalid = 4'h0;
    do_reset();
    mdl_valid = 1'b0;
    mdl_user  = '0;
    mdl_data  = '0;
    mdl_last  = N_CH - 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [3:0] req;
      logic [3:0] exp_rdy;
      logic       load;
      int         sel;
      s_tvalid = 4'($urandom);
      en_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      m_tready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N_CH; i++) set_chan(i, DW'($urandom));
      req  = s_tvalid & en_mask;
      load = !mdl_valid || m_tready;
      sel  = -1;
      for (int k = 1; k <= N_CH; k++) begin
        int c;
        c = (mdl_last + k) % N_CH;
        if (sel < 0 && req[c]) sel = c;
      end
      exp_rdy = (load && sel >= 0) ? 4'(1 << sel) : 4'h0;
      #1;
      check("rnd.tready", 32'(s_tready), 32'(exp_rdy));
      check("rnd.onehot", 32'($countones(s_tready) <= 1), 32'd1);
      if (mdl_valid && m_tready) begin
        if (sb_q.size() == 0) begin
          check("rnd.sb_empty", 32'(m_tvalid), 32'd0);
        end else begin
          logic [25:0] b;
          b = sb_q.pop_front();
          check("rnd.sb_beat", 32'({m_tuser, m_tdata}), 32'(b));
          $display("[TB] rnd beat: u=%0d d=%06h", m_tuser, m_tdata);
        end
      end
      if (load) begin
        if (sel >= 0) begin
          mdl_valid = 1'b1;
          mdl_user  = 2'(sel);
          mdl_data  = s_tdata[sel*DW +: DW];
          mdl_last  = sel;
          sb_q.push_back({mdl_user, mdl_data});
        end else begin
          mdl_valid = 1'b0;
        end
      end
      tick();
      check_out("rnd", mdl_valid, mdl_user, mdl_data);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_rr_mux.md
AXIS_RR_MUX -- requirements
Module: axis_rr_mux

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning the number of AXIS input channels; legal range is 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 24, meaning the sample width in bits.
REQ-003 SHALL have localparam ID_WIDTH = clog2(N_CH), the channel-tag width.
REQ-004 SHALL have port aclk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port en_mask, input, N_CH bits: per-channel enable; 1 = channel may be granted.
REQ-007 SHALL have port s_axis_tdata, input, N_CH*DATA_WIDTH bits: channel i occupies [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port s_axis_tvalid, input, N_CH bits: per-channel valid.
REQ-009 SHALL have port s_axis_tready, output, N_CH bits: per-channel ready.
REQ-010 SHALL have port m_axis_tdata, output, DATA_WIDTH bits: merged sample, registered.
REQ-011 SHALL have port m_axis_tuser, output, ID_WIDTH bits: source channel of m_axis_tdata, registered.
REQ-012 SHALL have port m_axis_tvalid, output, 1 bit: output beat valid, registered.
REQ-013 SHALL have port m_axis_tready, input, 1 bit: downstream (AXIS reader) ready.

Function
REQ-014 SHALL define request req[i] = s_axis_tvalid[i] & en_mask[i].
REQ-015 SHALL hold a round-robin pointer last; the grant sel is the first i with req[i]=1, searching last+1, last+2, ... mod N_CH.
REQ-016 SHALL define load = ~m_axis_tvalid | m_axis_tready, i.e. the output register is empty or draining this cycle.
REQ-017 SHALL drive s_axis_tready[i] = load & (|req) & (i == sel), combinationally; at most one bit is set in any cycle, and it is zero for every unrequested or masked channel.
REQ-018 SHALL, on a cycle with load & (|req), register tdata[sel] into m_axis_tdata, register sel into m_axis_tuser, set m_axis_tvalid=1, and update last <= sel.
REQ-019 SHALL, on a cycle with load & ~(|req), clear m_axis_tvalid and leave tdata, tuser and last unchanged.
REQ-020 SHALL, while m_axis_tvalid=1 and m_axis_tready=0, hold m_axis_tdata, m_axis_tuser and m_axis_tvalid stable (AXIS stall rule).
REQ-021 SHALL have a latency of 1 cycle from input handshake to m_axis_tvalid, and a throughput of 1 beat/cycle with m_axis_tready held at 1.
REQ-022 SHALL implement two states: EMPTY (m_axis_tvalid=0) and FULL (m_axis_tvalid=1).
- EMPTY -> FULL on |req.
- FULL -> EMPTY on m_axis_tready & ~(|req).
- FULL -> FULL on ~m_axis_tready, or on m_axis_tready & |req (back-to-back transfer).
REQ-023 SHALL, when all N_CH channels request continuously, grant them in strict rotation 0,1,...,N_CH-1,0,... with no channel skipped.
REQ-024 SHALL grant a lone requester on every load cycle; no idle insertion.
REQ-025 SHALL, when en_mask clears a channel, still deliver an already-registered beat from that channel; the channel's tready is 0 from that same cycle.
REQ-026 SHALL treat pointer wrap from N_CH-1 to 0 as ordinary; no special case at the wrap.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, and last=N_CH-1, so channel 0 has first priority.
REQ-028 SHALL hold s_axis_tready=0 on all bits while rst=1.
REQ-029 SHALL, when rst is asserted mid-operation, discard any held output beat; no beat is emitted after reset until a new request arrives.

Structure
REQ-030 SHALL place the ID_WIDTH computation (clog2 function) and the state encoding EMPTY/FULL in shared package axis_rr_pkg.
REQ-031 SHALL implement the combinational rotate-and-priority search in sub-module axis_rr_pick (inputs req and last; outputs sel and any).

Verification
REQ-032 SHALL cover: after reset, all four channels valid with tdata=i+1 and m_axis_tready=1 -> outputs (tdata,tuser) = (1,0),(2,1),(3,2),(4,3),(1,0), one beat per cycle.
REQ-033 SHALL cover: only channel 2 valid with tdata=24'h0000FF -> beat tuser=2 emitted every cycle, with s_axis_tready=4'b0100.
REQ-034 SHALL cover: m_axis_tready=0 for 5 cycles while FULL with 24'h8000FF -> output stable all 5 cycles, all s_axis_tready=0; the beat is accepted on the cycle m_axis_tready rises.
REQ-035 SHALL cover: en_mask=4'b1010 with all channels valid -> tuser sequence 1,3,1,3; s_axis_tready[0] and s_axis_tready[2] never asserted.
REQ-036 SHALL cover: rst pulsed while FULL and stalled -> m_axis_tvalid=0 the next cycle; the next grant goes to channel 0 if it is requesting.
REQ-037 SHALL cover: a scoreboard check under random tvalid/tready -> no beat lost or duplicated, and at most one bit of s_axis_tready set per cycle.
